top: RTL and testbench
======================

Name: top

Overview:
- FPGA top level for the iCE40 board, running from a 12 MHz clock.
- Blinks a heartbeat LED.
- Drives an external 12-bit SPI DAC (MCP4921-style, 16-bit command frame) with a free-running ramp waveform at a fixed sample rate.
- Provides a debug strobe pin for scope triggering.

Parameters:
- CLK_HZ, 12000000, input clock frequency (informational; used for defaults).
- LED_HALF_PERIOD, 6000000, clock cycles between LED toggles (1 Hz blink).
- SAMPLE_PERIOD, 600, clock cycles between DAC frames (20 kHz); must be >= 40.
- RAMP_STEP, 16, 12-bit increment applied to the DAC code after each frame.
- DAC_CONFIG, 4'b0011, upper 4 command bits: channel A, unbuffered, gain 1x, output active.

Ports:
- i_Clock  input  1  system clock, 12 MHz, all logic on rising edge.
- reset_n  input  1  asynchronous, active-high reset (port name retained despite suffix); while 1, all state is held at reset values.
- led  output  1  heartbeat LED.
- test  output  1  debug strobe, high for one cycle at each sample tick.
- o_DAC_MOSI  output  1  SPI data to DAC, MSB first.
- o_DAC_SCK  output  1  SPI clock, mode 0 (idle low, DAC samples on rising edge).
- o_DAC_CS  output  1  SPI chip select, active low.

Behaviour:
- Reset values:
  - led=0, test=0, o_DAC_MOSI=0, o_DAC_SCK=0, o_DAC_CS=1.
  - LED counter=0, sample counter=0, ramp code=0, FSM=IDLE.
- Reset mid-frame aborts immediately: CS returns high and SCK low asynchronously. The next frame after release starts with ramp code 0.
- LED:
  - Counter runs 0..LED_HALF_PERIOD-1.
  - led toggles on the cycle the counter wraps; first toggle LED_HALF_PERIOD cycles after reset release.
- Sample tick:
  - Counter runs 0..SAMPLE_PERIOD-1.
  - tick asserts for one cycle when the count equals SAMPLE_PERIOD-1; first tick at cycle SAMPLE_PERIOD-1 after release.
  - test is the registered tick, so it goes high one cycle after the tick and stays high one cycle.
- Frame word: {DAC_CONFIG[3:0], ramp[11:0]}, 16 bits, latched into a shift register at the tick.
- FSM IDLE:
  - CS=1, SCK=0.
  - On tick: go to SHIFT.
  - A tick arriving while not IDLE is ignored. This cannot occur given the SAMPLE_PERIOD >= 40 constraint.
- FSM SHIFT, with cycle index k counted from the first SHIFT cycle (k=0):
  - k=0: CS falls, MOSI=bit15, SCK=0.
  - Odd k=1..31: SCK=1, MOSI stable.
  - Even k=2..30: SCK=0, MOSI advances to the next lower bit.
  - After k=31: go to DONE.
- FSM DONE:
  - One cycle: SCK=0, CS=1, MOSI=0.
  - ramp <= (ramp + RAMP_STEP) mod 4096.
  - Return to IDLE.
- Timing results:
  - CS is low for exactly 32 cycles.
  - 16 SCK rising edges, 6 MHz SCK.
  - MOSI changes only while SCK is low.
- Ramp wraps from 4080 to 0 with the default step: 256 frames per period, 78.125 Hz sawtooth.

Optional Feature:
- Macro: DAC_TRIANGLE_EN.
- Defined:
  - A direction bit (reset 0 = up) is added.
  - Going up, when ramp + RAMP_STEP would exceed 4095, ramp is set to 4095 and direction flips to down.
  - Going down, when ramp < RAMP_STEP, ramp is set to 0 and direction flips to up.
  - Result is a symmetric triangle wave.
- Undefined: sawtooth wrap as above; no direction register.

Test Plan:
- Reset held 1000 ns, then released: during reset CS=1, SCK=0, MOSI=0, led=0, test=0. No activity until cycle 599 after release; test pulses high on the following cycle.
- First frame: CS low 32 cycles, 16 SCK rising edges; bits sampled on rising edges = 16'h3000.
- Second and third frames carry 16'h3010 and 16'h3020. Consecutive CS falling edges are 600 cycles (50 µs) apart.
- Run 257 frames: frame 256 = 16'h3FF0, frame 257 = 16'h3000 (wrap). With DAC_TRIANGLE_EN, frame 257 = 16'h3FFF and then 16'h3FEF.
- Assert reset during frame bit 8: CS goes high and SCK low without waiting for a clock edge. After release the next frame is 16'h3000.
- Run LED_HALF_PERIOD overridden to 100: led toggles every 100 cycles, 0→1 at cycle 100 after release.

Source files
------------

// File: rtl/top.sv
// iCE40 top: heartbeat LED, scope strobe and a ramp waveform streamed to a 12-bit SPI DAC.
// Define DAC_TRIANGLE_EN to turn the sawtooth into a symmetric triangle wave.
module top #(
  parameter int unsigned CLK_HZ          = 12000000,
  parameter int unsigned LED_HALF_PERIOD = CLK_HZ / 2,
  parameter int unsigned SAMPLE_PERIOD   = CLK_HZ / 20000,
  parameter logic [11:0] RAMP_STEP       = 12'd16,
  parameter logic [3:0]  DAC_CONFIG      = 4'b0011
) (
  input  logic i_Clock,
  input  logic reset_n,
  output logic led,
  output logic test,
  output logic o_DAC_MOSI,
  output logic o_DAC_SCK,
  output logic o_DAC_CS
);

  localparam int unsigned LedW = (LED_HALF_PERIOD > 1) ? $clog2(LED_HALF_PERIOD) : 1;
  localparam int unsigned SmpW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [LedW-1:0] LedLast = LedW'(LED_HALF_PERIOD - 1);
  localparam logic [SmpW-1:0] SmpLast = SmpW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [4:0]      bit_q, bit_d;
  logic [15:0]     shift_q, shift_d;
  logic [11:0]     ramp_q, ramp_d;
  logic [LedW-1:0] led_cnt_q;
  logic [SmpW-1:0] smp_cnt_q;
  logic            led_q;
  logic            test_q;
  logic            tick;

`ifdef DAC_TRIANGLE_EN
  logic        dir_q, dir_d;
  logic [12:0] up_sum;
  assign up_sum = {1'b0, ramp_q} + {1'b0, RAMP_STEP};
`endif

  assign tick = (smp_cnt_q == SmpLast);

  always_ff @(posedge i_Clock or posedge reset_n) begin
    if (reset_n) begin
      led_cnt_q <= '0;
      led_q     <= 1'b0;
      smp_cnt_q <= '0;
      test_q    <= 1'b0;
    end else begin
      if (led_cnt_q == LedLast) begin
        led_cnt_q <= '0;
        led_q     <= ~led_q;
      end else begin
        led_cnt_q <= led_cnt_q + 1'b1;
      end
      smp_cnt_q <= tick ? '0 : smp_cnt_q + 1'b1;
      test_q    <= tick;
    end
  end

  always_ff @(posedge i_Clock or posedge reset_n) begin
    if (reset_n) begin
      state_q <= StIdle;
      bit_q   <= '0;
      shift_q <= '0;
      ramp_q  <= '0;
`ifdef DAC_TRIANGLE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ramp_q  <= ramp_d;
`ifdef DAC_TRIANGLE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ramp_d  = ramp_q;
`ifdef DAC_TRIANGLE_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StShift;
          bit_d   = '0;
          shift_d = {DAC_CONFIG, ramp_q};
        end
      end
      StShift: begin
        bit_d = bit_q + 5'd1;
        // Advance MOSI on the edge that drops SCK, so data only moves while SCK is low.
        if (bit_q[0] && (bit_q != 5'd31)) shift_d = {shift_q[14:0], 1'b0};
        if (bit_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
`ifdef DAC_TRIANGLE_EN
        if (!dir_q) begin
          if (up_sum > 13'd4095) begin
            ramp_d = 12'hFFF;
            dir_d  = 1'b1;
          end else begin
            ramp_d = up_sum[11:0];
          end
        end else begin
          if (ramp_q < RAMP_STEP) begin
            ramp_d = 12'h000;
            dir_d  = 1'b0;
          end else begin
            ramp_d = ramp_q - RAMP_STEP;
          end
        end
`else
        ramp_d = ramp_q + RAMP_STEP;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded straight from reset-cleared state so an abort releases CS/SCK asynchronously.
  assign o_DAC_CS   = (state_q != StShift);
  assign o_DAC_SCK  = (state_q == StShift) && bit_q[0];
  assign o_DAC_MOSI = (state_q == StShift) && shift_q[15];
  assign led        = led_q;
  assign test       = test_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: reset state, strobe/LED timing, DAC frame contents and spacing,
// ramp wrap (or triangle turn with DAC_TRIANGLE_EN) and asynchronous mid-frame abort.
module tb_top;

  // Sample period shortened so 258 frames fit a short run; LED period shortened likewise.
  localparam int SP  = 200;
  localparam int LHP = 100;

  typedef struct {
    int          idx;
    logic [15:0] word;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    int          nrise;
    int          lowlen;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led, test, mosi, sck, cs;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  frame_t frames[$];
  int     fall_q[$];
  logic [15:0] mon_bits;
  int     mon_nrise  = 0;
  int     mon_lowlen = 0;
  int     mosi_viol  = 0;
  logic   prev_cs    = 1'b1;
  logic   prev_sck   = 1'b0;
  logic   prev_mosi  = 1'b0;

  top #(
    .LED_HALF_PERIOD(LHP),
    .SAMPLE_PERIOD  (SP)
  ) dut (
    .i_Clock   (clk),
    .reset_n   (rst),
    .led       (led),
    .test      (test),
    .o_DAC_MOSI(mosi),
    .o_DAC_SCK (sck),
    .o_DAC_CS  (cs)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Frame monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (prev_cs && !cs) begin
      fall_q.push_back(cyc);
      mon_bits   = '0;
      mon_nrise  = 0;
      mon_lowlen = 0;
    end
    if (!cs) mon_lowlen++;
    if (sck && !prev_sck) begin
      mon_bits = {mon_bits[14:0], mosi};
      mon_nrise++;
    end
    if (sck && (mosi != prev_mosi)) mosi_viol++;
    if (!prev_cs || cs) begin
      if (!prev_cs && cs) frames.push_back('{word: mon_bits, nrise: mon_nrise, lowlen: mon_lowlen});
    end
    prev_cs   = cs;
    prev_sck  = sck;
    prev_mosi = mosi;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("frame_wait", 32'(frames.size() >= n), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{idx: 0,   word: 16'h3000};
    vecs[1] = '{idx: 1,   word: 16'h3010};
    vecs[2] = '{idx: 2,   word: 16'h3020};
    vecs[3] = '{idx: 255, word: 16'h3FF0};
`ifdef DAC_TRIANGLE_EN
    vecs[4] = '{idx: 256, word: 16'h3FFF};
    vecs[5] = '{idx: 257, word: 16'h3FEF};
`else
    vecs[4] = '{idx: 256, word: 16'h3000};
    vecs[5] = '{idx: 257, word: 16'h3010};
`endif

    #1000;
    check("rst_led", led, 1'b0);
    check("rst_test", test, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_sck", sck, 1'b0);
    check("rst_cs", cs, 1'b1);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 2 * LHP + 5; i++) begin
      @(negedge clk);
      if (cyc == SP - 1) check("test_before_tick", test, 1'b0);
      if (cyc == SP - 1) check("cs_before_tick", cs, 1'b1);
      if (cyc == SP)     check("test_pulse", test, 1'b1);
      if (cyc == SP + 1) check("test_one_cycle", test, 1'b0);
      if (cyc == LHP - 1) check("led_before", led, 1'b0);
      if (cyc == LHP)     check("led_rise", led, 1'b1);
      if (cyc == 2*LHP-1) check("led_hold", led, 1'b1);
      if (cyc == 2*LHP)   check("led_fall", led, 1'b0);
    end

    wait_frames(258, 260 * SP);
    if (fall_q.size() > 0) check("first_cs_fall", 32'(fall_q[0]), 32'(SP));

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].idx < frames.size()) begin
        check($sformatf("word[%0d]", vecs[v].idx), 32'(frames[vecs[v].idx].word),
              32'(vecs[v].word));
        check($sformatf("sck_rises[%0d]", vecs[v].idx), 32'(frames[vecs[v].idx].nrise), 32'd16);
        check($sformatf("cs_low[%0d]", vecs[v].idx), 32'(frames[vecs[v].idx].lowlen), 32'd32);
        if (vecs[v].idx > 0)
          check($sformatf("spacing[%0d]", vecs[v].idx),
                32'(fall_q[vecs[v].idx] - fall_q[vecs[v].idx - 1]), 32'(SP));
      end else begin
        check($sformatf("missing[%0d]", vecs[v].idx), 32'd0, 32'd1);
      end
    end
    check("mosi_stable_while_sck_high", 32'(mosi_viol), 32'd0);

    // Abort a frame mid-way once bit 8 has been clocked into the DAC.
    begin
      int c = 0;
      while (!(mon_nrise == 8 && !cs) && c < 2 * SP) begin
        @(negedge clk);
        c++;
      end
      check("abort_reached_bit8", 32'(mon_nrise == 8 && !cs), 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    check("abort_cs_async", cs, 1'b1);
    check("abort_sck_async", sck, 1'b0);
    repeat (3) @(negedge clk);
    frames.delete();
    fall_q.delete();
    rst = 1'b0;
    wait_frames(1, 2 * SP);
    if (frames.size() > 0) check("after_abort_word", 32'(frames[0].word), 32'h3000);
    if (fall_q.size() > 0) check("after_abort_fall", 32'(fall_q[0]), 32'(SP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
